// File: rtl/reg_snapshot.sv
// -----------------------------------------------------------------------------
// reg_snapshot
//
// Debug capture unit that sits between a CPU register-file debug read port
// and a host. A start command walks registers 0..NUM_REGS-1 through reg_sel,
// waits READ_LAT extra cycles per register for reg_data to settle, and stores
// each word in an internal snapshot array. The host reads the array through
// rd_idx/rd_data at its own pace. Outside a scan, host_sel is passed straight
// through to reg_sel for manual single-register inspection.
//
// Optional feature: define REG_SNAPSHOT_CHECKSUM_EN to build a running
// modulo-2^DATA_W sum of the captured words on the checksum output. Without
// it, checksum is tied to zero and no accumulator exists.
//
// Parameters
//   DATA_W    register word width
//   NUM_REGS  number of registers scanned (1..2^SEL_W)
//   SEL_W     register selector width
//   READ_LAT  extra cycles from a reg_sel change to valid reg_data (0..15)
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rstn      asynchronous active-low reset
//   start     begin a scan (sampled only in IDLE)
//   abort     cancel a scan in progress; wins over start
//   host_sel  selector passed to reg_sel when not scanning
//   reg_sel   selector driven to the CPU
//   reg_data  register word returned by the CPU
//   busy      high while scanning
//   done      one-cycle pulse when a scan completes
//   valid     snapshot array holds a complete scan
//   rd_idx    snapshot read index
//   rd_data   combinational snapshot word, 0 for rd_idx >= NUM_REGS
//   checksum  sum of captured words (0 unless REG_SNAPSHOT_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module reg_snapshot #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int SEL_W    = 5,
  parameter int READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  host_sel,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic              done,
  output logic              valid,
  input  logic [SEL_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] checksum
);

  // Array index width; the selector may be wider than the array needs.
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);
  localparam logic [3:0]       LAT      = 4'(READ_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic               valid_q, valid_d;

  // Decoded per-cycle events.
  logic               accept;
  logic               cap_en;

  // Snapshot storage: deliberately not reset, only meaningful while valid=1.
  logic [DATA_W-1:0]  mem_q [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Next-state and capture control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    valid_d = valid_q;
    accept  = 1'b0;
    cap_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = S_SCAN;
          idx_d   = '0;
          wcnt_d  = LAT;
          valid_d = 1'b0;
        end
      end

      S_SCAN: begin
        if (abort) begin
          // valid was already cleared when the scan was accepted.
          state_d = S_IDLE;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          cap_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            // valid rises together with the DONE cycle.
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            wcnt_d = LAT;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot array write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cap_en) begin
      mem_q[idx_q[IDX_W-1:0]] <= reg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The CPU sees the scan index only while scanning, the host otherwise.
  assign reg_sel = (state_q == S_SCAN) ? idx_q : host_sel;
  assign busy    = (state_q == S_SCAN);
  assign done    = (state_q == S_DONE);
  assign valid   = valid_q;

  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < NUM_REGS) begin
      rd_data = mem_q[rd_idx[IDX_W-1:0]];
    end
  end

`ifdef REG_SNAPSHOT_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running checksum of the current scan
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      csum_d = '0;
    end else if (cap_en) begin
      csum_d = csum_q + reg_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
